diff_ser_tx: RTL
================

DIFF_SER_TX -- requirements
Module: diff_ser_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame (legal range 1..32).
REQ-002 SHALL have parameter CLKDIV, default 4, meaning CLK cycles per serial bit (legal range 1..256).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port EN  input  1  transmitter enable, level-sensitive.
REQ-007 SHALL have port DATA  input  DATA_WIDTH  payload word.
REQ-008 SHALL have port VALID  input  1  DATA valid request.
REQ-009 SHALL have port READY  output  1  word accepted when VALID and READY on the same edge.
REQ-010 SHALL have port BUSY  output  1  frame in progress.
REQ-011 SHALL have port O  output  1  true side of the differential serial line.
REQ-012 SHALL have port OB  output  1  complement side of the differential serial line.
REQ-013 SHALL have port FRAME_CNT  output  16  count of completed frames.

Function
REQ-014 SHALL implement the states IDLE, START, DATA and STOP.
REQ-015 SHALL drive O and OB from registers, with OB equal to the inverse of O in every cycle including reset.
REQ-016 SHALL drive READY = 1 only while in IDLE with EN = 1, and 0 otherwise.
REQ-017 SHALL, on a handshake (VALID & READY), capture DATA into a shift register and enter START on the next edge; DATA changes after capture SHALL have no effect.
REQ-018 SHALL hold O = 0 in START for exactly CLKDIV cycles, then enter DATA.
REQ-019 SHALL, in DATA, send DATA_WIDTH bits LSB-first, each held for exactly CLKDIV cycles on O.
REQ-020 SHALL, after the last data bit, hold O = 1 in STOP for exactly CLKDIV cycles.
REQ-021 SHALL, at the end of STOP, return to IDLE and increment FRAME_CNT by 1.
REQ-022 SHALL wrap FRAME_CNT from 0xFFFF to 0x0000 without a flag.
REQ-023 SHALL hold O = 1 in IDLE.
REQ-024 SHALL assert BUSY = 1 in START, DATA and STOP, and BUSY = 0 in IDLE.
REQ-025 SHALL time bits with a bit-period counter that counts 0..CLKDIV-1 and a bit index that counts 0..DATA_WIDTH-1; both SHALL clear on every state entry.
REQ-026 SHALL produce a first START cycle on O one cycle after the handshake edge.
REQ-027 SHALL give a frame length of (DATA_WIDTH+2)*CLKDIV cycles, and SHALL spend at least one IDLE cycle (READY high) between frames, so the minimum handshake-to-handshake period is (DATA_WIDTH+2)*CLKDIV+1 cycles.
REQ-028 SHALL, when EN falls mid-frame, complete the current frame normally; READY SHALL stay 0 until EN = 1 again.
REQ-029 SHALL, when VALID is asserted while BUSY, neither accept the word nor disturb the frame in progress.
REQ-030 SHALL support CLKDIV = 1 with each bit lasting exactly one cycle and no skipped or repeated bits.

Reset
REQ-031 SHALL, while RST_N = 0, immediately force: state IDLE, O = 1, OB = 0, READY = 0, BUSY = 0, FRAME_CNT = 0, counters = 0.
REQ-032 SHALL, when RST_N is asserted mid-frame, abort the frame; FRAME_CNT SHALL not increment for the aborted frame.
REQ-033 SHALL, after RST_N deasserts, drive READY = EN from the first rising edge onward.

Verification
REQ-034 SHALL cover: DATA_WIDTH=8, CLKDIV=4, EN=1, send 0xA5 -> O = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; OB = ~O throughout; FRAME_CNT 0 -> 1; total 40 cycles.
REQ-035 SHALL cover: VALID held high with 0x00, then 0xFF -> handshakes exactly 41 cycles apart; O shows 8 low bits, then 8 high bits; READY is low during each frame.
REQ-036 SHALL cover: EN dropped during bit 3 of 0x3C -> the frame completes intact; READY stays 0 until EN = 1; no second frame starts.
REQ-037 SHALL cover: RST_N pulsed low during DATA -> in the same cycle O = 1, OB = 0, BUSY = 0 and FRAME_CNT = 0; READY goes high on the first edge after release.
REQ-038 SHALL cover: CLKDIV=1 with 0x81 -> O sequence 0,1,0,0,0,0,0,0,1,1 over 10 cycles.
REQ-039 SHALL cover: FRAME_CNT preloaded to 0xFFFF by running 65535 frames -> after one more frame FRAME_CNT = 0x0000.

Source files
------------

// File: rtl/diff_ser_tx.sv
// Differential serial transmitter: one start bit (0), DATA_WIDTH payload bits
// sent LSB-first, one stop bit (1), each held for CLKDIV clocks. O/OB are a
// registered complementary pair. FRAME_CNT counts completed frames.
module diff_ser_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLKDIV     = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] DATA,
  input  logic                  VALID,
  output logic                  READY,
  output logic                  BUSY,
  output logic                  O,
  output logic                  OB,
  output logic [15:0]           FRAME_CNT
);

  localparam int unsigned CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  o_reg, ob_reg, o_nxt;
  logic                  frame_done, bit_end;
  logic [15:0]           frame_cnt;
  // Set on the first clock edge after reset release; gates READY so it
  // follows EN only from that edge onward.
  logic                  run;

  assign READY     = (state == S_IDLE) && EN && run;
  assign BUSY      = (state != S_IDLE);
  assign O         = o_reg;
  assign OB        = ob_reg;
  assign FRAME_CNT = frame_cnt;

  // Next-state, bit timing and shift logic; line value is derived from the
  // next state so O changes on the same edge the state does.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shreg_nxt  = shreg;
    frame_done = 1'b0;
    o_nxt      = 1'b1;
    bit_end    = (cnt == CNT_LAST);
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (VALID && READY) begin
          shreg_nxt = DATA;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = S_STOP;
            idx_nxt   = '0;
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shreg >> 1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_nxt  = S_IDLE;
          cnt_nxt    = '0;
          frame_done = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
    case (state_nxt)
      S_START: o_nxt = 1'b0;
      S_DATA:  o_nxt = shreg_nxt[0];
      default: o_nxt = 1'b1;
    endcase
  end

  // State, counters, line pair and frame counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      o_reg     <= 1'b1;
      ob_reg    <= 1'b0;
      frame_cnt <= '0;
      run       <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      shreg  <= shreg_nxt;
      o_reg  <= o_nxt;
      ob_reg <= ~o_nxt;
      run    <= 1'b1;
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule
